// File: rtl/usb_rx_packet_sequencer_if.sv
// Bitstream-in / framed-bytes-out bundle of the USB receive packet sequencer.
// The slave side is the sequencer itself; the master side is its environment
// (NRZI decoder feeding bits, packet parser observing the framed bytes).
interface usb_rx_packet_sequencer_if #(
   parameter int MAX_BYTES = 64
);
   logic                           bit_in;
   logic                           bit_valid;
   logic [7:0]                     byte_out;
   logic                           byte_valid;
   logic                           pkt_start;
   logic                           pkt_done;
   logic [1:0]                     err_code;
   logic [$clog2(MAX_BYTES+1)-1:0] byte_count;
   logic                           rx_busy;

   // Sequencer view: consumes the decoded bitstream, produces packet framing.
   modport slave (
      input  bit_in,
      input  bit_valid,
      output byte_out,
      output byte_valid,
      output pkt_start,
      output pkt_done,
      output err_code,
      output byte_count,
      output rx_busy
   );

   // Environment view: drives the bitstream, observes packet framing.
   modport master (
      output bit_in,
      output bit_valid,
      input  byte_out,
      input  byte_valid,
      input  pkt_start,
      input  pkt_done,
      input  err_code,
      input  byte_count,
      input  rx_busy
   );
endinterface

// File: rtl/usb_rx_packet_sequencer.sv
// USB receive packet sequencer. Sits after the NRZI decoder: hunts for the
// SYNC pattern, removes stuffed bits, assembles LSB-first bytes and frames
// each packet with start/done strobes and a two-bit status code.
module usb_rx_packet_sequencer #(
   parameter int MAX_BYTES    = 64,
   parameter int SYNC_TIMEOUT = 32,
   parameter int TAIL_BITS    = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   usb_rx_packet_sequencer_if.slave bus
);
   localparam int CountWidth = $clog2(MAX_BYTES + 1);
   localparam int TotalWidth = $clog2(SYNC_TIMEOUT + 1);

   localparam logic [CountWidth-1:0] MaxCount     = CountWidth'(MAX_BYTES);
   localparam logic [TotalWidth-1:0] TimeoutLimit = TotalWidth'(SYNC_TIMEOUT);
   localparam logic [3:0]            TailLimit    = 4'(TAIL_BITS);

   localparam logic [1:0] ErrNone   = 2'b00;
   localparam logic [1:0] ErrSync   = 2'b01;
   localparam logic [1:0] ErrStuff  = 2'b10;
   localparam logic [1:0] ErrLength = 2'b11;

   localparam logic [7:0] SyncPattern = 8'b0000_0001;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      DATA,
      DRAIN
   } state_e;

   state_e                state_q,     state_d;
   logic [7:0]            syncSr_q,    syncSr_d;
   logic [TotalWidth-1:0] bitTotal_q,  bitTotal_d;
   logic [7:0]            byteSr_q,    byteSr_d;
   logic [3:0]            bitCnt_q,    bitCnt_d;
   logic [2:0]            onesCnt_q,   onesCnt_d;
   logic [1:0]            drainErr_q,  drainErr_d;
   logic [CountWidth-1:0] byteCount_q, byteCount_d;
   logic [1:0]            errCode_q,   errCode_d;
   logic [7:0]            byteOut_q,   byteOut_d;
   logic                  byteValid_q, byteValid_d;
   logic                  pktStart_q,  pktStart_d;
   logic                  pktDone_q,   pktDone_d;
   logic                  rxBusy_q,    rxBusy_d;

   logic [7:0]            syncNext;
   logic [7:0]            byteNext;
   logic [TotalWidth-1:0] bitTotalInc;

   // State, counters, shift registers and every output are held here so no
   // input reaches an output without passing through a flop.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         syncSr_q    <= '0;
         bitTotal_q  <= '0;
         byteSr_q    <= '0;
         bitCnt_q    <= '0;
         onesCnt_q   <= '0;
         drainErr_q  <= '0;
         byteCount_q <= '0;
         errCode_q   <= '0;
         byteOut_q   <= '0;
         byteValid_q <= 1'b0;
         pktStart_q  <= 1'b0;
         pktDone_q   <= 1'b0;
         rxBusy_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         syncSr_q    <= syncSr_d;
         bitTotal_q  <= bitTotal_d;
         byteSr_q    <= byteSr_d;
         bitCnt_q    <= bitCnt_d;
         onesCnt_q   <= onesCnt_d;
         drainErr_q  <= drainErr_d;
         byteCount_q <= byteCount_d;
         errCode_q   <= errCode_d;
         byteOut_q   <= byteOut_d;
         byteValid_q <= byteValid_d;
         pktStart_q  <= pktStart_d;
         pktDone_q   <= pktDone_d;
         rxBusy_q    <= rxBusy_d;
      end
   end

   // Per-bit sequencing: SYNC hunt, destuffing, byte assembly and packet
   // delimiting. Strobes default low; everything else holds unless changed.
   // Every return to IDLE clears the per-packet working state so each hunt
   // starts exactly as it would after reset.
   always_comb begin
      state_d     = state_q;
      syncSr_d    = syncSr_q;
      bitTotal_d  = bitTotal_q;
      byteSr_d    = byteSr_q;
      bitCnt_d    = bitCnt_q;
      onesCnt_d   = onesCnt_q;
      drainErr_d  = drainErr_q;
      byteCount_d = byteCount_q;
      errCode_d   = errCode_q;
      byteOut_d   = byteOut_q;
      byteValid_d = 1'b0;
      pktStart_d  = 1'b0;
      pktDone_d   = 1'b0;

      syncNext    = {syncSr_q[6:0], bus.bit_in};
      byteNext    = {bus.bit_in, byteSr_q[7:1]};
      bitTotalInc = bitTotal_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (bus.bit_valid) begin
               syncSr_d   = syncNext;
               bitTotal_d = TotalWidth'(1);
               state_d    = SYNC;
            end
         end

         SYNC: begin
            if (bus.bit_valid) begin
               syncSr_d   = syncNext;
               bitTotal_d = bitTotalInc;
               if (syncNext == SyncPattern) begin
                  // The closing 1 of SYNC already counts toward a stuffing run.
                  pktStart_d  = 1'b1;
                  byteCount_d = '0;
                  errCode_d   = ErrNone;
                  bitCnt_d    = '0;
                  onesCnt_d   = 3'd1;
                  byteSr_d    = '0;
                  state_d     = DATA;
               end else if (bitTotalInc >= TimeoutLimit) begin
                  drainErr_d = ErrSync;
                  state_d    = DRAIN;
               end
            end else begin
               // Line went quiet before SYNC: abandon without reporting.
               syncSr_d   = '0;
               bitTotal_d = '0;
               state_d    = IDLE;
            end
         end

         DATA: begin
            if (bus.bit_valid) begin
               if (onesCnt_q == 3'd6) begin
                  if (!bus.bit_in) begin
                     onesCnt_d = '0;
                  end else begin
                     drainErr_d = ErrStuff;
                     state_d    = DRAIN;
                  end
               end else begin
                  onesCnt_d = bus.bit_in ? (onesCnt_q + 3'd1) : 3'd0;
                  byteSr_d  = byteNext;
                  if (bitCnt_q == 4'd7) begin
                     bitCnt_d = '0;
                     if (byteCount_q == MaxCount) begin
                        drainErr_d = ErrLength;
                        state_d    = DRAIN;
                     end else begin
                        byteOut_d   = byteNext;
                        byteValid_d = 1'b1;
                        byteCount_d = byteCount_q + 1'b1;
                     end
                  end else begin
                     bitCnt_d = bitCnt_q + 4'd1;
                  end
               end
            end else begin
               // End of packet: a short residue is tolerated, more is a length error.
               pktDone_d  = 1'b1;
               errCode_d  = (bitCnt_q > TailLimit) ? ErrLength : ErrNone;
               syncSr_d   = '0;
               bitTotal_d = '0;
               byteSr_d   = '0;
               bitCnt_d   = '0;
               onesCnt_d  = '0;
               drainErr_d = '0;
               state_d    = IDLE;
            end
         end

         DRAIN: begin
            if (!bus.bit_valid) begin
               pktDone_d  = 1'b1;
               errCode_d  = drainErr_q;
               syncSr_d   = '0;
               bitTotal_d = '0;
               byteSr_d   = '0;
               bitCnt_d   = '0;
               onesCnt_d  = '0;
               drainErr_d = '0;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      rxBusy_d = (state_d != IDLE);
   end

   assign bus.byte_out   = byteOut_q;
   assign bus.byte_valid = byteValid_q;
   assign bus.pkt_start  = pktStart_q;
   assign bus.pkt_done   = pktDone_q;
   assign bus.err_code   = errCode_q;
   assign bus.byte_count = byteCount_q;
   assign bus.rx_busy    = rxBusy_q;

endmodule

// File: doc/usb_rx_packet_sequencer.md
Name: usb_rx_packet_sequencer

Overview:
- Sequences the USB receive bitstream after the NRZI decoder.
- Consumes decoded bits and their valid qualifier.
- Per bit: hunts for SYNC, strips stuffed bits, assembles LSB-first bytes, and delimits the packet.
- Hands bytes to the packet/PID layer with start/done/error framing. Sits between the NRZI decoder and the packet parser.

Parameters:
- MAX_BYTES, 64: maximum data bytes per packet after SYNC; one more byte is a length error.
- SYNC_TIMEOUT, 32: number of valid bits allowed in SYNC hunt before error.
- TAIL_BITS, 1: residual (non-byte-aligned) bits tolerated at end of packet without error.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- bit_in  in  1  decoded bit from NRZI decoder
- bit_valid  in  1  bit_in qualified this cycle; falling edge marks end of packet
- byte_out  out  8  assembled byte, LSB = first received bit
- byte_valid  out  1  one-cycle strobe, byte_out valid
- pkt_start  out  1  one-cycle strobe, SYNC matched
- pkt_done  out  1  one-cycle strobe, packet finished
- err_code  out  2  packet status, valid with pkt_done: 00 ok, 01 sync timeout, 10 stuff error, 11 length error
- byte_count  out  $clog2(MAX_BYTES+1)  bytes delivered in current/last packet
- rx_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high, any state):
  - State goes to IDLE; all outputs 0; all internal counters and shift registers cleared.
  - First cycle after release with bit_valid=1 starts a new SYNC hunt.
- States: IDLE, SYNC, DATA, DRAIN.
- IDLE: bit_valid=1 -> shift bit_in into sync_sr, bit_total=1, go SYNC.
- SYNC, each bit_valid=1 cycle:
  - sync_sr <= {sync_sr[6:0], bit_in}.
  - If {sync_sr[6:0], bit_in} == 8'b0000_0001: pkt_start=1 next cycle, byte_count<=0, bit_cnt<=0, ones_cnt<=1 (SYNC's final 1 counts toward stuffing), go DATA.
  - Else if bit_total reaches SYNC_TIMEOUT: go DRAIN with err 01.
  - bit_valid=0 in SYNC -> silent return to IDLE: no pkt_done, err_code unchanged.
- DATA, each bit_valid=1 cycle:
  - ones_cnt==6 and bit_in=0: stuffed bit; discard; ones_cnt<=0.
  - ones_cnt==6 and bit_in=1: stuff error; go DRAIN with err 10.
  - Otherwise accept the bit:
    - byte_sr <= {bit_in, byte_sr[7:1]}; bit_cnt++.
    - ones_cnt <= bit_in ? ones_cnt+1 : 0.
  - On 8th accepted bit, next cycle: byte_out = assembled byte, byte_valid=1, byte_count++, bit_cnt<=0.
  - If byte_count already equals MAX_BYTES when a byte completes: byte not delivered, go DRAIN with err 11.
- DATA, bit_valid=0:
  - Next cycle pkt_done=1, go IDLE.
  - err_code = 11 if bit_cnt > TAIL_BITS, else 00. Residual bits are discarded.
- DRAIN:
  - Ignore bits while bit_valid=1.
  - On bit_valid=0: next cycle pkt_done=1 with latched error code, go IDLE.
- Simultaneous events: if the 8th bit is the last valid cycle, byte_valid pulses on the cycle bit_valid drops and pkt_done pulses the following cycle. byte_valid and pkt_done are never high together.
- Latency:
  - byte_valid: 1 cycle after the byte's last accepted bit.
  - pkt_start: 1 cycle after the SYNC-completing bit.
  - pkt_done: 1 cycle after bit_valid first seen low in DATA/DRAIN.
- Output holding:
  - byte_out holds its value until the next byte_valid.
  - byte_count and err_code hold from pkt_done until the next pkt_start.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Good packet: bits 0,0,0,0,0,0,0,1 then 1,0,1,0,0,1,0,1, then bit_valid=0 -> pkt_start 1 cycle after 8th bit; byte_valid with byte_out=0xA5 1 cycle after 16th bit; pkt_done next cycle, err_code=00, byte_count=1.
- Bit stuffing: SYNC, data 1,1,1,1,1, stuffed 0, then 1,1,1, then end -> byte_out=0xFF, err 00, count 1. Same stream with 1 in place of the stuffed 0 -> no byte_valid, pkt_done with err 10 after bit_valid drops.
- SYNC timeout: 32 valid zeros then bit_valid=0 -> no pkt_start; pkt_done with err 01. Separately, 5 zeros then bit_valid=0 -> no pkt_done, rx_busy returns 0.
- Length: MAX_BYTES=2, SYNC + bytes 0x01,0x02,0x03 -> two byte_valid (0x01, 0x02), pkt_done err 11, byte_count=2. Also SYNC + 0x3C + 3 extra bits -> byte 0x3C delivered, err 11; same with 1 extra bit -> err 00.
- Reset mid-DATA: assert reset after 4 data bits -> all outputs 0 immediately; release with bit_valid low; next good packet of 0x5A is received correctly with count 1.
